// File: rtl/sym_unpacker_if.sv
// Word-in / symbol-out handshake bundle for the 3-bit symbol unpacker.
// slave: the unpacker itself; master: whatever feeds words and drains symbols.
interface sym_unpacker_if #(
   parameter int WORD_W = 32,
   parameter int SYM_W  = 3,
   parameter int IDX_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [WORD_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [SYM_W-1:0]  out_sym;
   logic [IDX_W-1:0]  out_idx;
   logic              out_last;
   logic              chk_valid;
   logic [WORD_W-1:0] chk;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_sym, out_idx, out_last, chk_valid, chk
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_sym, out_idx, out_last, chk_valid, chk
   );
endinterface

// File: rtl/sym_unpacker.sv
// Unpacks 32-bit words into eleven 3-bit symbols, LSB first; first symbol one cycle after accept.
// Symbols hold under out_ready stall; in_ready rises only on the final symbol handshake (no bubble).
module sym_unpacker (
   input logic           clk,
   input logic           rst_n,
   sym_unpacker_if.slave bus
);
   localparam int        WORD_W   = 32;
   localparam int        SYM_W    = 3;
   localparam int        NSYM     = (WORD_W + SYM_W - 1) / SYM_W;
   localparam logic [3:0] LAST_IDX = 4'(NSYM - 1);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_SHIFT = 1'b1;

   logic [0:0]        r_state;
   logic [WORD_W-1:0] r_shreg;
   logic [3:0]        r_idx;
   logic [WORD_W-1:0] r_acc;
   logic [WORD_W-1:0] r_chk;
   logic              r_chk_vld;

   logic              w_shift;
   logic              w_last;
   logic              w_sym_hs;
   logic              w_in_rdy;
   logic              w_in_hs;
   logic [3:0]        w_weight;
   logic [6:0]        w_prod;
   logic [WORD_W-1:0] w_acc_nxt;

   assign w_shift   = (r_state == S_SHIFT);
   assign w_last    = w_shift && (r_idx == LAST_IDX);
   assign w_sym_hs  = w_shift && bus.out_ready;
   // Combinational path from out_ready lets the next word load on the final symbol cycle.
   assign w_in_rdy  = !w_shift || (w_last && bus.out_ready);
   assign w_in_hs   = bus.in_valid && w_in_rdy;
   assign w_weight  = r_idx + 4'd1;
   assign w_prod    = 7'(r_shreg[SYM_W-1:0]) * 7'(w_weight);
   assign w_acc_nxt = r_acc + WORD_W'(w_prod);

   assign bus.in_ready  = w_in_rdy;
   assign bus.out_valid = w_shift;
   assign bus.out_sym   = w_shift ? r_shreg[SYM_W-1:0] : '0;
   assign bus.out_idx   = w_shift ? r_idx : 4'd0;
   assign bus.out_last  = w_last;
   assign bus.chk_valid = r_chk_vld;
   assign bus.chk       = r_chk;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_shreg   <= '0;
         r_idx     <= 4'd0;
         r_acc     <= '0;
         r_chk     <= '0;
         r_chk_vld <= 1'b0;
      end else begin
         r_chk_vld <= 1'b0;
         if (w_in_hs) begin
            r_state <= S_SHIFT;
            r_shreg <= bus.in_data;
            r_idx   <= 4'd0;
            r_acc   <= '0;
         end else if (w_sym_hs) begin
            r_shreg <= r_shreg >> SYM_W;
            r_idx   <= w_last ? 4'd0 : r_idx + 4'd1;
            r_acc   <= w_acc_nxt;
            if (w_last) begin
               r_state <= S_IDLE;
            end
         end
         // The finishing word's checksum is captured even when a new word loads alongside.
         if (w_sym_hs && w_last) begin
            r_chk     <= w_acc_nxt;
            r_chk_vld <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sym_unpacker.sv
// Randomised bench for sym_unpacker: a queue-based model of the symbol stream and checksums
// predicts every output each cycle, sampled on the falling edge.
module tb_sym_unpacker;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   sym_unpacker_if bus ();

   sym_unpacker dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]  sym_q[$];   // {idx, sym} still owed by the unpacker
   logic [31:0] sum_q[$];   // running checksum after each owed symbol
   logic [31:0] m_chk;
   logic        m_chk_vld;
   bit          accepted;
   bit          saw4;
   int          or_mode;

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      logic [31:0] sum;
      logic [31:0] tmp;
      logic [2:0]  s;
      sum = 32'd0;
      for (int k = 0; k < 11; k++) begin
         tmp = w >> (3 * k);
         s   = tmp[2:0];
         sum = sum + 32'(s) * 32'(k + 1);
         sym_q.push_back({4'(k), s});
         sum_q.push_back(sum);
      end
   endtask

   task automatic step();
      bit          exp_vld;
      bit          exp_rdy;
      bit          last_hs;
      logic [6:0]  e;
      logic [31:0] wchk;
      @(negedge clk);
      exp_vld = (sym_q.size() != 0);
      exp_rdy = (sym_q.size() == 0) || (sym_q.size() == 1 && bus.out_ready);
      expect_eq("out_valid", 32'(bus.out_valid), 32'(exp_vld));
      expect_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
      expect_eq("chk_valid", 32'(bus.chk_valid), 32'(m_chk_vld));
      expect_eq("chk", bus.chk, m_chk);
      if (exp_vld) begin
         e = sym_q[0];
         expect_eq("out_sym", 32'(bus.out_sym), 32'(e[2:0]));
         expect_eq("out_idx", 32'(bus.out_idx), 32'(e[6:3]));
         expect_eq("out_last", 32'(bus.out_last), 32'(e[6:3] == 4'd10));
      end
      accepted = 1'b0;
      last_hs  = 1'b0;
      wchk     = 32'd0;
      if (rst_n) begin
         if (exp_vld && bus.out_ready) begin
            e = sym_q.pop_front();
            wchk = sum_q.pop_front();
            if (e[6:3] == 4'd4) saw4 = 1'b1;
            if (e[6:3] == 4'd10) last_hs = 1'b1;
         end
         if (bus.in_valid && exp_rdy) begin
            push_word(bus.in_data);
            accepted = 1'b1;
         end
         m_chk_vld = last_hs;
         if (last_hs) m_chk = wchk;
      end else begin
         sym_q.delete();
         sum_q.delete();
         m_chk     = 32'd0;
         m_chk_vld = 1'b0;
      end
      @(posedge clk);
      #1;
      case (or_mode)
         0:       bus.out_ready = 1'b1;
         1:       bus.out_ready = 1'($urandom_range(0, 1));
         default: bus.out_ready = ~bus.out_ready;
      endcase
   endtask

   task automatic send(input logic [31:0] w, input int gap);
      int n;
      bus.in_valid = 1'b0;
      for (int g = 0; g < gap; g++) step();
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      n = 0;
      do begin
         step();
         n++;
      end while (!accepted && n < 300);
      if (!accepted) expect_eq("accept_timeout", 32'(n), 32'd0);
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sym_q.size() != 0 || m_chk_vld) && n < 500) begin
         step();
         n++;
      end
      step();
   endtask

   initial begin
      int n;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 32'd0;
      bus.out_ready = 1'b1;
      m_chk         = 32'd0;
      m_chk_vld     = 1'b0;
      saw4          = 1'b0;
      or_mode       = 0;
      repeat (2) @(posedge clk);
      #1;
      step();
      rst_n = 1'b1;
      step();

      // Directed, full rate; the last pair goes back-to-back
      send(32'h0000_0005, 0);
      drain();
      send(32'hFFFF_FFFF, 2);
      drain();
      send(32'h0000_0008, 1);
      send(32'hFFFF_FFFF, 0);
      drain();

      // Alternate-cycle stalls, with the next word waiting during SHIFT
      or_mode = 2;
      send(32'hFFFF_FFFF, 0);
      send(32'h0000_0008, 0);
      send(32'h1234_5678, 0);
      or_mode = 0;
      drain();

      // Reset after symbol 4 of a word, then a clean word
      saw4 = 1'b0;
      send($urandom, 0);
      n = 0;
      while (!saw4 && n < 50) begin
         step();
         n++;
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      send(32'h0000_0005, 0);
      drain();

      // Random words, gaps and out_ready
      or_mode = 1;
      for (int i = 0; i < 40; i++) begin
         send($urandom, $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 4)) : 0);
      end
      or_mode = 0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
